// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a valid/ready native memory bus.
// The grant is held for one whole transaction, and a watchdog force-completes a hung slave.
module mem_arbiter #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout,
    output logic [7:0]  timeout_cnt
);

    localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last;
    logic              last_next;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_next;
    logic              owner_valid;
    logic              expire;
    logic              done;
    logic [31:0]       rdata_mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            wdog        <= '0;
            timeout_cnt <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            wdog  <= wdog_next;
            if (expire && timeout_cnt != 8'hFF) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        last_next   = last;
        wdog_next   = wdog;
        owner_valid = 1'b0;
        expire      = 1'b0;
        case (state)
            IDLE: begin
                wdog_next = '0;
                // On contention, the master that was not served last wins.
                if (m0_valid && m1_valid) begin
                    state_next = last ? G0 : G1;
                end else if (m0_valid) begin
                    state_next = G0;
                end else if (m1_valid) begin
                    state_next = G1;
                end
            end
            G0, G1: begin
                owner_valid = (state == G0) ? m0_valid : m1_valid;
                if (!owner_valid) begin
                    // Withdrawn request: drop the grant without crediting the master.
                    state_next = IDLE;
                    wdog_next  = '0;
                end else if (s_ready) begin
                    state_next = IDLE;
                    last_next  = (state == G1);
                    wdog_next  = '0;
                end else if (TIMEOUT > 0 && wdog == WDOG_LAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                    last_next  = (state == G1);
                    wdog_next  = '0;
                end else if (TIMEOUT > 0) begin
                    wdog_next = wdog + WDOG_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign done      = owner_valid && (s_ready || expire);
    assign rdata_mux = expire ? ERR_DATA : s_rdata;
    assign s_valid   = owner_valid;
    assign grant     = {state == G1, state == G0};
    assign timeout   = expire;

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        case (state)
            G0: begin
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
            G1: begin
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end
            default: ;
        endcase
    end

    assign m0_ready = (state == G0) && done;
    assign m1_ready = (state == G1) && done;
    assign m0_rdata = (state == G0) ? rdata_mux : '0;
    assign m1_rdata = (state == G1) ? rdata_mux : '0;

endmodule
